// File: rtl/m_time_set_ctrl.sv
// m_time_set_ctrl
//   Mode/set controller for the HH:MM:SS clock chain. In RUN it forwards the
//   1 Hz tick to the counter chain. In SET_HOUR / SET_MIN / SET_SEC it turns the
//   debounced mode/inc buttons into single-cycle increment/clear pulses, with
//   auto-repeat, blink blanking and a return-to-RUN timeout.
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   tick_1hz            one-clk pulse per second from the divider
//   btn_mode, btn_inc   debounced buttons, level, active-high
//   run_en              seconds-advance pulse (RUN only)
//   inc_min, inc_hour   one-cycle increment pulses
//   clr_sec             one-cycle seconds clear pulse
//   mode                0=RUN 1=SET_HOUR 2=SET_MIN 3=SET_SEC
//   blank_hour/min      blink-phase blanking of the digits being set
module m_time_set_ctrl #(
  parameter int unsigned CNT_W      = 26,
  parameter int unsigned REPEAT_DLY = 25_000_000,
  parameter int unsigned REPEAT_PER = 5_000_000,
  parameter int unsigned TIMEOUT_S  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       run_en,
  output logic       inc_min,
  output logic       inc_hour,
  output logic       clr_sec,
  output logic [1:0] mode,
  output logic       blank_hour,
  output logic       blank_min
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT_S + 1);
  localparam logic [CNT_W-1:0]  REP_FIRST  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  REP_LAST   = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0]  REP_RELOAD = CNT_W'(REPEAT_DLY - REPEAT_PER);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT_S - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } mode_e;

  mode_e             mode_q, mode_d;
  logic              btn_mode_q, btn_mode_d;
  logic              btn_mode_prev_q, btn_mode_prev_d;
  logic              btn_inc_q, btn_inc_d;
  logic              btn_inc_prev_q, btn_inc_prev_d;
  logic [CNT_W-1:0]  rep_cnt_q, rep_cnt_d;
  logic              armed_q, armed_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              phase_q, phase_d;
  logic              run_en_q, run_en_d;
  logic              inc_min_q, inc_min_d;
  logic              inc_hour_q, inc_hour_d;
  logic              clr_sec_q, clr_sec_d;
  logic              blank_hour_q, blank_hour_d;
  logic              blank_min_q, blank_min_d;

  logic rise_mode;
  logic rise_inc;
  logic set_mode;
  logic mode_chg;
  logic rep_pulse;

  // Edges are taken between two registered samples so the resulting pulse
  // appears one cycle after the button is first sampled high.
  assign rise_mode = btn_mode_q & ~btn_mode_prev_q;
  assign rise_inc  = btn_inc_q  & ~btn_inc_prev_q;
  assign set_mode  = (mode_q != RUN);

  always_comb begin
    mode_d          = mode_q;
    btn_mode_d      = btn_mode;
    btn_mode_prev_d = btn_mode_q;
    btn_inc_d       = btn_inc;
    btn_inc_prev_d  = btn_inc_q;
    rep_cnt_d       = rep_cnt_q;
    armed_d         = armed_q;
    idle_cnt_d      = idle_cnt_q;
    phase_d         = phase_q;
    run_en_d        = tick_1hz & (mode_q == RUN);
    inc_min_d       = 1'b0;
    inc_hour_d      = 1'b0;
    clr_sec_d       = 1'b0;
    mode_chg        = 1'b0;
    rep_pulse       = 1'b0;

    if (rise_mode) begin
      mode_chg = 1'b1;
      unique case (mode_q)
        RUN:      mode_d = SET_HOUR;
        SET_HOUR: mode_d = SET_MIN;
        SET_MIN:  mode_d = SET_SEC;
        SET_SEC:  mode_d = RUN;
        default:  mode_d = RUN;
      endcase
    end else if (set_mode && tick_1hz && (idle_cnt_q == IDLE_LAST) && !rise_inc) begin
      mode_d   = RUN;
      mode_chg = 1'b1;
    end else if (set_mode && rise_inc) begin
      unique case (mode_q)
        SET_HOUR: begin
          inc_hour_d = 1'b1;
          armed_d    = 1'b1;
          rep_cnt_d  = REP_FIRST;
        end
        SET_MIN: begin
          inc_min_d = 1'b1;
          armed_d   = 1'b1;
          rep_cnt_d = REP_FIRST;
        end
        SET_SEC: clr_sec_d = 1'b1;
        default: ;
      endcase
    end else if (armed_q && btn_inc_q) begin
      // Reload instead of wrapping: the counter never passes REP_LAST.
      if (rep_cnt_q == REP_LAST) begin
        rep_pulse = 1'b1;
        rep_cnt_d = REP_RELOAD;
      end else begin
        rep_cnt_d = rep_cnt_q + REP_FIRST;
      end
    end else begin
      armed_d   = 1'b0;
      rep_cnt_d = '0;
    end

    if (rep_pulse) begin
      inc_hour_d = (mode_q == SET_HOUR);
      inc_min_d  = (mode_q == SET_MIN);
    end

    if (mode_chg || !set_mode || rise_inc || rep_pulse) begin
      idle_cnt_d = '0;
    end else if (tick_1hz) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end

    if (mode_chg) begin
      armed_d   = 1'b0;
      rep_cnt_d = '0;
      phase_d   = 1'b0;
    end else if (tick_1hz) begin
      phase_d = ~phase_q;
    end

    // Digits stay visible while inc is being held for auto-repeat.
    blank_hour_d = phase_d & (mode_d == SET_HOUR) & ~armed_d;
    blank_min_d  = phase_d & (mode_d == SET_MIN)  & ~armed_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q          <= RUN;
      btn_mode_q      <= 1'b0;
      btn_mode_prev_q <= 1'b0;
      btn_inc_q       <= 1'b0;
      btn_inc_prev_q  <= 1'b0;
      rep_cnt_q       <= '0;
      armed_q         <= 1'b0;
      idle_cnt_q      <= '0;
      phase_q         <= 1'b0;
      run_en_q        <= 1'b0;
      inc_min_q       <= 1'b0;
      inc_hour_q      <= 1'b0;
      clr_sec_q       <= 1'b0;
      blank_hour_q    <= 1'b0;
      blank_min_q     <= 1'b0;
    end else begin
      mode_q          <= mode_d;
      btn_mode_q      <= btn_mode_d;
      btn_mode_prev_q <= btn_mode_prev_d;
      btn_inc_q       <= btn_inc_d;
      btn_inc_prev_q  <= btn_inc_prev_d;
      rep_cnt_q       <= rep_cnt_d;
      armed_q         <= armed_d;
      idle_cnt_q      <= idle_cnt_d;
      phase_q         <= phase_d;
      run_en_q        <= run_en_d;
      inc_min_q       <= inc_min_d;
      inc_hour_q      <= inc_hour_d;
      clr_sec_q       <= clr_sec_d;
      blank_hour_q    <= blank_hour_d;
      blank_min_q     <= blank_min_d;
    end
  end

  assign run_en     = run_en_q;
  assign inc_min    = inc_min_q;
  assign inc_hour   = inc_hour_q;
  assign clr_sec    = clr_sec_q;
  assign mode       = mode_q;
  assign blank_hour = blank_hour_q;
  assign blank_min  = blank_min_q;

endmodule
